// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle MIPS16 FSM controller with memory request/ready handshake and stall-timeout fault trap.
// Define MC_BEQ_EN to build the BRANCH state (opcode 101); otherwise opcode 101 is illegal.
module multicycle_control_unit #(
  parameter int OP_W = 3,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IorD,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            MemToReg,
  output logic            Jump_EN,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic            illegal_op,
  output logic            fault,
  output logic [3:0]      state
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_BRANCH = 4'd12;
  localparam logic [3:0] S_FAULT  = 4'd15;
`ifdef MC_BEQ_EN
  localparam logic [OP_W-1:0] OP_MAX = OP_W'(5);
`else
  localparam logic [OP_W-1:0] OP_MAX = OP_W'(4);
  logic unused_zero;
  assign unused_zero = zero;
`endif
  logic [3:0]    next_state;
  logic [CW-1:0] stall_cnt;
  logic          is_sw;
  logic          stall;
  logic          bad_op;
  assign bad_op = op > OP_MAX;
  assign stall = mem_req && !mem_ready;
  // op is only valid in DECODE, so the lw/sw choice is latched there for MEMADR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RST;
      stall_cnt <= '0;
      is_sw <= 1'b0;
    end else begin
      state <= next_state;
      stall_cnt <= (next_state != state) ? '0 : stall_cnt + CW'(stall);
      if (state == S_DECODE) is_sw <= op == OP_W'(2);
    end
  end
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_RST:    next_state = S_FETCH;
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: next_state = bad_op ? S_FETCH : op == OP_W'(0) ? S_EXEC : op == OP_W'(3) ? S_JUMP :
                             op == OP_W'(4) ? S_ADDIEX : op == OP_W'(5) ? S_BRANCH : S_MEMADR;
      S_MEMADR: next_state = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_FETCH;
    endcase
    // the TIMEOUT-th consecutive stall cycle traps unless mem_ready arrives in it
    if (stall && stall_cnt == CW'(TIMEOUT - 1)) next_state = S_FAULT;
  end
  always_comb begin
    {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemToReg, Jump_EN, ALUSrcA, illegal_op, fault} = '0;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp = 2'b11;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
        ALUOp = 2'b11;
        illegal_op = bad_op;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp = 2'b11;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        MemWrite = 1'b1;
        IorD = 1'b1;
      end
      S_EXEC:   ALUSrcA = 1'b1;
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        Jump_EN = 1'b1;
        PCWrite = 1'b1;
      end
`ifdef MC_BEQ_EN
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCWrite = zero;
      end
`endif
      S_FAULT:  fault = 1'b1;
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed and randomized checks of the multicycle controller against a path-table model.
module tb_multicycle_control_unit;
  localparam int TIMEOUT = 4;
`ifdef MC_BEQ_EN
  localparam int OPMAX = 5;
`else
  localparam int OPMAX = 4;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic [2:0] op = 3'd0;
  logic mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemToReg, Jump_EN, ALUSrcA, illegal_op, fault;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] state;
  int checks = 0;
  int fails = 0;
  int path[6][3];
  int plen[6];
  int mst, mop, mk, mstalls, nst, nop, nk, nstalls;
  int cnt, cnt2;
  logic [19:0] seq;

  multicycle_control_unit #(.OP_W(3), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .Jump_EN(Jump_EN), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] dut_vec();
    return {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemToReg, Jump_EN,
            ALUSrcA, ALUSrcB, ALUOp, illegal_op, fault, state};
  endfunction

  // expected control word for a state, from the role each state plays
  function automatic logic [20:0] model_vec(input int s);
    logic mq, rd, wr, iord, irw, pcw, rw, rdst, m2r, jmp, sa, ill, flt;
    logic [1:0] sb, ao;
    mq = s inside {1, 4, 6};
    rd = s inside {1, 4};
    wr = s == 6;
    iord = s inside {4, 6};
    irw = s == 1 && mem_ready;
    pcw = (s == 1 && mem_ready) || s == 11 || (s == 12 && zero);
    rw = s inside {5, 8, 10};
    rdst = s == 8;
    m2r = s == 5;
    jmp = s == 11;
    sa = s inside {3, 7, 9, 12};
    sb = s == 1 ? 2'b01 : (s inside {2, 3, 9}) ? 2'b10 : 2'b00;
    ao = (s inside {1, 2, 3, 9}) ? 2'b11 : s == 12 ? 2'b01 : 2'b00;
    ill = s == 2 && int'(op) > OPMAX;
    flt = s == 15;
    return {mq, rd, wr, iord, irw, pcw, rw, rdst, m2r, jmp, sa, sb, ao, ill, flt, 4'(s)};
  endfunction

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mreset();
    mst = 0;
    mop = 0;
    mk = 0;
    mstalls = 0;
  endtask

  task automatic eval();
    logic stl;
    expect_eq($sformatf("cycle_st%0d", mst), 32'(dut_vec()), 32'(model_vec(mst)));
    stl = (mst inside {1, 4, 6}) && !mem_ready;
    nop = mop;
    nk = mk;
    if (mst == 0) nst = 1;
    else if (mst == 15) nst = 15;
    else if (stl) nst = (mstalls == TIMEOUT - 1) ? 15 : mst;
    else if (mst == 1) nst = 2;
    else if (mst == 2) begin
      if (int'(op) > OPMAX) nst = 1;
      else begin
        nop = int'(op);
        nk = 0;
        nst = path[nop][0];
      end
    end else begin
      nk = mk + 1;
      nst = nk < plen[mop] ? path[mop][nk] : 1;
    end
    nstalls = (stl && nst == mst) ? mstalls + 1 : 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    eval();
    @(posedge clk);
    if (rst) mreset();
    else begin
      mst = nst;
      mop = nop;
      mk = nk;
      mstalls = nstalls;
    end
    #2;
  endtask

  initial begin
    path = '{'{7, 8, 0}, '{3, 4, 5}, '{3, 6, 0}, '{11, 0, 0}, '{9, 10, 0}, '{12, 0, 0}};
    plen = '{2, 3, 2, 1, 2, 1};
    mreset();
    #1 rst = 1'b1;
    #1;
    expect_eq("rst_state", 32'(state), 0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    expect_eq("post_rst_fetch", 32'(state), 1);
    // lw with zero-wait memory
    mem_ready = 1'b1;
    op = 3'd1;
    seq = '0;
    cnt = 0;
    repeat (5) begin
      cnt += int'(RegWrite && MemToReg);
      cycle();
      seq = {seq[15:0], state};
    end
    expect_eq("lw_states", 32'(seq), 32'h23451);
    expect_eq("lw_regwrite_cycles", cnt, 1);
    // sw with three wait cycles
    op = 3'd2;
    cycle();
    cycle();
    cycle();
    expect_eq("sw_in_memwr", 32'(state), 6);
    cnt = 0;
    cnt2 = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = i == 3;
      #1;
      cnt += int'(mem_req && MemWrite);
      cnt2 += int'(RegWrite);
      cycle();
    end
    expect_eq("sw_req_cycles", cnt, 4);
    expect_eq("sw_regwrite", cnt2, 0);
    expect_eq("sw_back_fetch", 32'(state), 1);
    // ready in the last allowed stall cycle wins
    mem_ready = 1'b0;
    repeat (3) cycle();
    expect_eq("stall3_fetch", 32'(state), 1);
    mem_ready = 1'b1;
    cycle();
    expect_eq("timeout_ready_wins", 32'(state), 2);
    // illegal opcode
    op = 3'd6;
    #1;
    expect_eq("illegal_pulse", 32'({illegal_op, PCWrite, RegWrite}), 32'b100);
    cycle();
    expect_eq("illegal_to_fetch", 32'({state, illegal_op}), 32'b00010);
    // stall timeout into FAULT
    mem_ready = 1'b0;
    repeat (3) cycle();
    expect_eq("pre_timeout", 32'(state), 1);
    cycle();
    expect_eq("timeout_fault", 32'({state, fault}), 32'h1f);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      cycle();
    end
    expect_eq("fault_sticky", 32'({state, fault}), 32'h1f);
    rst = 1'b1;
    mreset();
    #1;
    expect_eq("fault_cleared", 32'({state, fault, mem_req}), 0);
    cycle();
    rst = 1'b0;
    cycle();
    expect_eq("fault_rst_fetch", 32'(state), 1);
    // opcode 101
    mem_ready = 1'b1;
    op = 3'd5;
    cycle();
`ifdef MC_BEQ_EN
    cycle();
    expect_eq("beq_state", 32'(state), 12);
    zero = 1'b1;
    #1;
    expect_eq("beq_taken", 32'(PCWrite), 1);
    zero = 1'b0;
    #1;
    expect_eq("beq_not_taken", 32'(PCWrite), 0);
`else
    #1;
    expect_eq("beq_illegal", 32'(illegal_op), 1);
`endif
    cycle();
    expect_eq("beq_to_fetch", 32'(state), 1);
    // reset mid-MEMRD
    op = 3'd1;
    cycle();
    cycle();
    mem_ready = 1'b0;
    cycle();
    expect_eq("in_memrd", 32'({state, mem_req}), 32'h9);
    rst = 1'b1;
    mreset();
    #1;
    expect_eq("rst_mid_memrd", 32'({state, mem_req}), 0);
    cycle();
    rst = 1'b0;
    cycle();
    expect_eq("memrd_rst_fetch", 32'(state), 1);
    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      op = 3'($urandom_range(0, 7));
      zero = 1'($urandom_range(0, 1));
      mem_ready = $urandom_range(0, 9) < 6;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        mreset();
      end
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
